// File: rtl/load_store_unit_if.sv
// Signal bundle between the load/store unit, the RV32I control unit and the data bus.
// Handshakes: a request transfers on the rising edge where req_valid && req_ready; rsp_valid is a one-cycle pulse; bus_req is held with stable fields until the edge where bus_ack is high.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [1:0]  dbg_state;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, bus_ack, bus_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, stall,
           bus_req, bus_we, bus_addr, bus_be, bus_wdata, dbg_state
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, bus_ack, bus_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, stall,
           bus_req, bus_we, bus_addr, bus_be, bus_wdata, dbg_state
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I data-memory stage: one word-aligned bus access per load/store,
// sign/zero extension of load data, error completion for misaligned/illegal/timeout.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input logic              clock,
  input logic              reset,
  load_store_unit_if.slave lsu
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  state_t state, state_nx;

  logic          we_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [29:0]   word_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          error_q;
  logic [CW-1:0] tmo_cnt;

  logic        req_legal, req_aligned, timeout_hit, in_access, in_resp;
  logic [3:0]  req_be;
  logic [31:0] req_wrep, load_ext;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Request decode: width from funct3[1:0], legality also depends on direction.
  always_comb begin
    req_aligned = 1'b0;
    req_be      = 4'b0000;
    req_wrep    = lsu.req_wdata;
    case (lsu.req_funct3[1:0])
      2'b00: begin
        req_aligned = 1'b1;
        req_be      = 4'b0001 << lsu.req_addr[1:0];
        req_wrep    = {4{lsu.req_wdata[7:0]}};
      end
      2'b01: begin
        req_aligned = ~lsu.req_addr[0];
        req_be      = 4'b0011 << {lsu.req_addr[1], 1'b0};
        req_wrep    = {2{lsu.req_wdata[15:0]}};
      end
      2'b10: begin
        req_aligned = (lsu.req_addr[1:0] == 2'b00);
        req_be      = 4'b1111;
      end
      default: ;
    endcase
    case (lsu.req_funct3)
      3'b000, 3'b001, 3'b010: req_legal = 1'b1;
      3'b100, 3'b101:         req_legal = ~lsu.req_we;
      default:                req_legal = 1'b0;
    endcase
  end

  always_comb begin
    lane_b = lsu.bus_rdata[{off_q, 3'b000} +: 8];
    lane_h = lsu.bus_rdata[{off_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_ext = {24'd0, lane_b};
      3'b101:  load_ext = {16'd0, lane_h};
      default: load_ext = lsu.bus_rdata;
    endcase
  end

  // A bus ack in the final allowed cycle still completes normally.
  assign timeout_hit = (TIMEOUT != 0) && !lsu.bus_ack && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (lsu.req_valid) state_nx = (req_legal && req_aligned) ? ACCESS : RESP;
      ACCESS:  if (lsu.bus_ack || timeout_hit) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      word_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (lsu.req_valid) begin
          we_q    <= lsu.req_we;
          f3_q    <= lsu.req_funct3;
          off_q   <= lsu.req_addr[1:0];
          word_q  <= lsu.req_addr[31:2];
          be_q    <= req_be;
          wdata_q <= req_wrep;
          rdata_q <= '0;
          error_q <= ~(req_legal & req_aligned);
          tmo_cnt <= '0;
        end
        ACCESS: begin
          if (lsu.bus_ack) begin
            rdata_q <= we_q ? 32'd0 : load_ext;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (timeout_hit) error_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus and response fields are gated by state so they read zero when idle.
  assign in_access     = (state == ACCESS);
  assign in_resp       = (state == RESP);
  assign lsu.req_ready = (state == IDLE);
  assign lsu.stall     = (state != IDLE);
  assign lsu.bus_req   = in_access;
  assign lsu.bus_we    = in_access & we_q;
  assign lsu.bus_addr  = in_access ? {word_q, 2'b00} : 32'd0;
  assign lsu.bus_be    = in_access ? be_q : 4'b0000;
  assign lsu.bus_wdata = in_access ? wdata_q : 32'd0;
  assign lsu.rsp_valid = in_resp;
  assign lsu.rsp_rdata = in_resp ? rdata_q : 32'd0;
  assign lsu.rsp_error = in_resp & error_q;
  assign lsu.dbg_state = state;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// transactions checked against a byte-level behavioural model.
`timescale 1ns/1ps
module tb_load_store_unit;
  localparam int TIMEOUT = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        ready_before;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    int          high_cnt;
    logic        early_rsp;
    logic        rsp_seen;
    logic        err;
    logic [31:0] rdata;
    logic        ready_after;
  } obs_t;

  typedef struct {
    logic        bus;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          high;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  load_store_unit_if lsu_if();
  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (.clock(clock), .reset(reset), .lsu(lsu_if));

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish by 500us");
    $fatal(1, "watchdog expired");
  end

  // Byte-granular model: size in bytes, offset within the word, lane replication by modulo.
  function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata, input int ack_wait);
    exp_t e;
    int size, off;
    logic legal;
    longint v, m;
    off = int'(addr % 4);
    size = 0;
    legal = 1'b1;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    legal = 1'b0;
    endcase
    if (we && f3 >= 3'd4) legal = 1'b0;
    e.bus = legal ? ((off % (size == 0 ? 1 : size)) == 0) : 1'b0;
    e.addr = addr - 32'(off);
    e.be = 4'(((1 << size) - 1) << off);
    e.wdata = 32'd0;
    if (legal) for (int k = 0; k < 4; k++) e.wdata[8*k +: 8] = wdata[8*(k % size) +: 8];
    e.high = !e.bus ? 0 : ((ack_wait < TIMEOUT) ? ack_wait + 1 : TIMEOUT);
    e.err = !e.bus || (ack_wait >= TIMEOUT);
    e.rdata = 32'd0;
    if (!e.err && !we) begin
      v = longint'(rdata >> (8*off));
      m = (longint'(1) << (8*size)) - 1;
      v = v & m;
      if (f3 < 3'd4 && size < 4 && v >= (m + 1) / 2) v = v - (m + 1);
      e.rdata = 32'(v);
    end
    return e;
  endfunction

  // driver tasks
  task automatic idle_inputs();
    lsu_if.req_valid  = 1'b0;
    lsu_if.req_we     = 1'b0;
    lsu_if.req_funct3 = 3'd0;
    lsu_if.req_addr   = 32'd0;
    lsu_if.req_wdata  = 32'd0;
    lsu_if.bus_ack    = 1'b0;
    lsu_if.bus_rdata  = 32'd0;
  endtask

  task automatic drive_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input int ack_wait,
                           output obs_t o);
    o.addr = '0; o.be = '0; o.wdata = '0; o.we = 1'b0; o.high_cnt = 0; o.early_rsp = 1'b0;
    @(negedge clock);
    o.ready_before = lsu_if.req_ready;
    lsu_if.req_valid = 1'b1; lsu_if.req_we = we; lsu_if.req_funct3 = f3;
    lsu_if.req_addr = addr; lsu_if.req_wdata = wdata;
    @(negedge clock);
    lsu_if.req_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (lsu_if.bus_req !== 1'b1) break;
      if (i == 0) begin
        o.addr = lsu_if.bus_addr; o.be = lsu_if.bus_be; o.wdata = lsu_if.bus_wdata; o.we = lsu_if.bus_we;
      end
      if (lsu_if.rsp_valid !== 1'b0) o.early_rsp = 1'b1;
      o.high_cnt++;
      lsu_if.bus_ack = (i == ack_wait);
      lsu_if.bus_rdata = rdata;
      @(negedge clock);
      lsu_if.bus_ack = 1'b0;
    end
    o.rsp_seen = lsu_if.rsp_valid;
    o.err = lsu_if.rsp_error;
    o.rdata = lsu_if.rsp_rdata;
    @(negedge clock);
    o.ready_after = lsu_if.req_ready && !lsu_if.rsp_valid;
  endtask

  task automatic test_reset();
    idle_inputs();
    lsu_if.req_valid = 1'b1;
    lsu_if.bus_ack = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    tests_run++;
    if ({lsu_if.req_ready, lsu_if.bus_req, lsu_if.bus_we, lsu_if.stall, lsu_if.rsp_valid, lsu_if.rsp_error} !== 6'b100000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b want 100000", {lsu_if.req_ready, lsu_if.bus_req, lsu_if.bus_we, lsu_if.stall, lsu_if.rsp_valid, lsu_if.rsp_error});
    end
    tests_run++;
    if ({lsu_if.bus_addr, lsu_if.bus_be, lsu_if.bus_wdata, lsu_if.rsp_rdata} !== 100'd0) begin
      tests_failed++;
      $display("FAIL reset_data: got addr %h be %b wdata %h rdata %h want all zero", lsu_if.bus_addr, lsu_if.bus_be, lsu_if.bus_wdata, lsu_if.rsp_rdata);
    end
    idle_inputs();
    reset = 1'b0;
  endtask

  task automatic test_word_load();
    obs_t o;
    drive_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2, o);
    tests_run++;
    if (o.addr !== 32'h100 || o.be !== 4'b1111 || o.we !== 1'b0) begin
      tests_failed++; $display("FAIL word_load_bus: got addr %h be %b we %b want 00000100 1111 0", o.addr, o.be, o.we);
    end
    tests_run++;
    if (o.high_cnt != 3 || o.rsp_seen !== 1'b1) begin
      tests_failed++; $display("FAIL word_load_latency: got bus cycles %0d rsp %b want 3 1", o.high_cnt, o.rsp_seen);
    end
    tests_run++;
    if (o.rdata !== 32'hDEADBEEF || o.err !== 1'b0) begin
      tests_failed++; $display("FAIL word_load_data: got %h err %b want deadbeef 0", o.rdata, o.err);
    end
  endtask

  task automatic test_byte_load();
    obs_t o;
    logic [31:0] want[2];
    logic [2:0] f3s[2];
    want[0] = 32'hFFFFFF80; want[1] = 32'h00000080;
    f3s[0] = 3'b000; f3s[1] = 3'b100;
    for (int j = 0; j < 2; j++) begin
      drive_txn(1'b0, f3s[j], 32'h103, $urandom, {8'h80, 24'($urandom)}, $urandom_range(0, 2), o);
      tests_run++;
      if (o.be !== 4'b1000 || o.addr !== 32'h100) begin
        tests_failed++; $display("FAIL byte_load_be[%0d]: got be %b addr %h want 1000 00000100", j, o.be, o.addr);
      end
      tests_run++;
      if (o.rdata !== want[j] || o.err !== 1'b0) begin
        tests_failed++; $display("FAIL byte_load_data[%0d]: got %h err %b want %h 0", j, o.rdata, o.err, want[j]);
      end
    end
  endtask

  task automatic test_half_store();
    obs_t o;
    drive_txn(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'hFFFFFFFF, 1, o);
    tests_run++;
    if (o.wdata !== 32'hABCDABCD || o.be !== 4'b1100 || o.we !== 1'b1) begin
      tests_failed++; $display("FAIL half_store_bus: got wdata %h be %b we %b want abcdabcd 1100 1", o.wdata, o.be, o.we);
    end
    tests_run++;
    if (o.rsp_seen !== 1'b1 || o.rdata !== 32'd0 || o.err !== 1'b0) begin
      tests_failed++; $display("FAIL half_store_rsp: got valid %b rdata %h err %b want 1 00000000 0", o.rsp_seen, o.rdata, o.err);
    end
  endtask

  task automatic test_errors();
    obs_t o;
    drive_txn(1'b0, 3'b010, 32'h101, 32'h0, 32'h12345678, 0, o);
    tests_run++;
    if (o.high_cnt != 0 || o.rsp_seen !== 1'b1 || o.err !== 1'b1 || o.rdata !== 32'd0) begin
      tests_failed++; $display("FAIL misaligned_word: got bus cycles %0d rsp %b err %b rdata %h want 0 1 1 0", o.high_cnt, o.rsp_seen, o.err, o.rdata);
    end
    drive_txn(1'b1, 3'b100, 32'h200, 32'hCAFEF00D, 32'h0, 0, o);
    tests_run++;
    if (o.high_cnt != 0 || o.rsp_seen !== 1'b1 || o.err !== 1'b1 || o.ready_after !== 1'b1) begin
      tests_failed++; $display("FAIL illegal_store: got bus cycles %0d rsp %b err %b ready %b want 0 1 1 1", o.high_cnt, o.rsp_seen, o.err, o.ready_after);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    drive_txn(1'b0, 3'b010, 32'h300, 32'h0, 32'h55AA55AA, 99, o);
    tests_run++;
    if (o.high_cnt != TIMEOUT || o.rsp_seen !== 1'b1 || o.err !== 1'b1 || o.rdata !== 32'd0) begin
      tests_failed++; $display("FAIL timeout_abort: got bus cycles %0d rsp %b err %b rdata %h want %0d 1 1 0", o.high_cnt, o.rsp_seen, o.err, o.rdata, TIMEOUT);
    end
    drive_txn(1'b0, 3'b010, 32'h304, 32'h0, 32'h55AA55AA, TIMEOUT - 1, o);
    tests_run++;
    if (o.high_cnt != TIMEOUT || o.err !== 1'b0 || o.rdata !== 32'h55AA55AA) begin
      tests_failed++; $display("FAIL timeout_last_ack: got bus cycles %0d err %b rdata %h want %0d 0 55aa55aa", o.high_cnt, o.err, o.rdata, TIMEOUT);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    @(negedge clock);
    lsu_if.req_valid = 1'b1; lsu_if.req_we = 1'b0; lsu_if.req_funct3 = 3'b010; lsu_if.req_addr = 32'h400;
    @(negedge clock);
    lsu_if.req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    tests_run++;
    if ({lsu_if.bus_req, lsu_if.rsp_valid, lsu_if.req_ready, lsu_if.stall} !== 4'b0010) begin
      tests_failed++; $display("FAIL reset_mid: got req %b rsp %b ready %b stall %b want 0 0 1 0", lsu_if.bus_req, lsu_if.rsp_valid, lsu_if.req_ready, lsu_if.stall);
    end
    reset = 1'b0;
    drive_txn(1'b0, 3'b101, 32'h402, 32'h0, 32'hBEEF1234, 0, o);
    tests_run++;
    if (o.high_cnt != 1 || o.err !== 1'b0 || o.rdata !== 32'h0000BEEF) begin
      tests_failed++; $display("FAIL reset_mid_recover: got bus cycles %0d err %b rdata %h want 1 0 0000beef", o.high_cnt, o.err, o.rdata);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    lsu_if.req_valid = 1'b1; lsu_if.req_we = 1'b1; lsu_if.req_funct3 = 3'b111; lsu_if.req_addr = 32'h10;
    @(negedge clock);
    lsu_if.req_we = 1'b0; lsu_if.req_funct3 = 3'b010; lsu_if.req_addr = 32'h40;
    tests_run++;
    if (lsu_if.rsp_valid !== 1'b1 || lsu_if.rsp_error !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_error_rsp: got rsp %b err %b want 1 1", lsu_if.rsp_valid, lsu_if.rsp_error);
    end
    @(negedge clock);
    tests_run++;
    if (lsu_if.req_ready !== 1'b1 || lsu_if.bus_req !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_resp_no_accept: got ready %b req %b want 1 0", lsu_if.req_ready, lsu_if.bus_req);
    end
    @(negedge clock);
    lsu_if.req_valid = 1'b0;
    tests_run++;
    if (lsu_if.bus_req !== 1'b1 || lsu_if.bus_addr !== 32'h40) begin
      tests_failed++; $display("FAIL b2b_accept: got req %b addr %h want 1 00000040", lsu_if.bus_req, lsu_if.bus_addr);
    end
    lsu_if.bus_ack = 1'b1; lsu_if.bus_rdata = 32'h0BADF00D;
    @(negedge clock);
    lsu_if.bus_ack = 1'b0;
    tests_run++;
    if (lsu_if.rsp_valid !== 1'b1 || lsu_if.rsp_rdata !== 32'h0BADF00D) begin
      tests_failed++; $display("FAIL b2b_data: got rsp %b rdata %h want 1 0badf00d", lsu_if.rsp_valid, lsu_if.rsp_rdata);
    end
    @(negedge clock);
    lsu_if.bus_ack = 1'b1;
    @(negedge clock);
    @(negedge clock);
    lsu_if.bus_ack = 1'b0;
    tests_run++;
    if (lsu_if.rsp_valid !== 1'b0 || lsu_if.req_ready !== 1'b1) begin
      tests_failed++; $display("FAIL idle_ack_ignored: got rsp %b ready %b want 0 1", lsu_if.rsp_valid, lsu_if.req_ready);
    end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic we;
    logic [2:0] f3;
    logic [31:0] addr, wdata, rdata, want;
    int ack_wait;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom; wdata = $urandom; rdata = $urandom;
      ack_wait = $urandom_range(0, 5);
      e = model(we, f3, addr, wdata, rdata, ack_wait);
      exp_q.push_back(e.rdata);
      drive_txn(we, f3, addr, wdata, rdata, ack_wait, o);
      want = exp_q.pop_front();
      tests_run++;
      if (o.ready_before !== 1'b1 || o.rsp_seen !== 1'b1 || o.early_rsp !== 1'b0 || o.ready_after !== 1'b1) begin
        tests_failed++; $display("FAIL rand_handshake[%0d]: got ready %b rsp %b early %b after %b want 1 1 0 1", n, o.ready_before, o.rsp_seen, o.early_rsp, o.ready_after);
      end
      tests_run++;
      if (o.err !== e.err || o.rdata !== want) begin
        tests_failed++; $display("FAIL rand_rsp[%0d]: got err %b rdata %h want %b %h (we %b f3 %0d addr %h)", n, o.err, o.rdata, e.err, want, we, f3, addr);
      end
      tests_run++;
      if (o.high_cnt != e.high) begin
        tests_failed++; $display("FAIL rand_bus_cycles[%0d]: got %0d want %0d", n, o.high_cnt, e.high);
      end
      if (e.bus) begin
        tests_run++;
        if ({o.we, o.be, o.addr, o.wdata} !== {we, e.be, e.addr, e.wdata}) begin
          tests_failed++; $display("FAIL rand_bus_fields[%0d]: got we %b be %b addr %h wdata %h want %b %b %h %h", n, o.we, o.be, o.addr, o.wdata, we, e.be, e.addr, e.wdata);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
